ntt_input_loader: RTL and testbench



---
 rtl/ntt_input_loader.sv | 159 +++++++++++++++
 tb/tb_ntt_input_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_input_loader.sv
// ntt_input_loader: streams one raw coefficient per cycle, reduces it into [0, Q),
//   packs four consecutive coefficients into one conflict-free 4-bank write.
// Latency: the 4th accept of a group at edge T gives wr_en/a*/d* valid in cycle T+1.
// Backpressure: in_ready is high for the whole LOAD state; there is never a stall.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin a load (honoured only in IDLE)
//   in_valid/in_data/in_ready   coefficient handshake, natural order
//   wr_en, a0..a3, d0..d3       registered bank write port, held when wr_en=0
//   busy, load_done  LOAD/FLUSH indicator, one-cycle completion pulse
module ntt_input_loader #(
  parameter int DW = 12,
  parameter int Q  = 3329,
  parameter int N  = 128,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] a0,
  output logic [AW-1:0] a1,
  output logic [AW-1:0] a2,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] d0,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic [DW-1:0] d3,
  output logic          busy,
  output logic          load_done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [DW-1:0] QV = DW'(Q);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt;
  logic [DW-1:0] slot0, slot1, slot2;
  logic [DW-1:0] red;
  logic          accept;
  logic [1:0]    rot;
  logic [DW-1:0] lane [4];
  logic [DW-1:0] dn   [4];
  logic [1:0]    k;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (cnt == LAST_IDX)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign accept = in_valid && in_ready;

  // Inputs are below 2^DW <= 2Q, so one conditional subtract fully reduces.
  assign red = (in_data >= QV) ? (in_data - QV) : in_data;

  // Within a group the bank index is the member offset rotated by the
  // sum of the higher index fields, so rotating the lanes by that sum routes
  // each member to its bank and keeps all four banks distinct.
  assign rot = cnt[3:2] + cnt[5:4] + {1'b0, cnt[6]};

  always_comb begin
    lane[0] = slot0;
    lane[1] = slot1;
    lane[2] = slot2;
    lane[3] = red;
    k       = 2'd0;
    for (int b = 0; b < 4; b++) begin
      k     = 2'(b) - rot;
      dn[b] = lane[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
      slot2 <= '0;
      wr_en <= 1'b0;
      a0    <= '0;
      a1    <= '0;
      a2    <= '0;
      a3    <= '0;
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
      d3    <= '0;
    end else begin
      wr_en <= 1'b0;
      if ((state_q == S_IDLE) && start) begin
        cnt <= '0;
      end
      if (accept) begin
        cnt <= cnt + 1'b1;
        case (cnt[1:0])
          2'd0: slot0 <= red;
          2'd1: slot1 <= red;
          2'd2: slot2 <= red;
          default: begin
            // Group complete: slots are free again on the next accept.
            wr_en <= 1'b1;
            a0    <= cnt[CW-1:2];
            a1    <= cnt[CW-1:2];
            a2    <= cnt[CW-1:2];
            a3    <= cnt[CW-1:2];
            d0    <= dn[0];
            d1    <= dn[1];
            d2    <= dn[2];
            d3    <= dn[3];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ntt_input_loader.sv
// Bench for ntt_input_loader: directed table loads, randomized bubbled loads
// against a bank-memory reference model, reset and spurious-start sequences.
module tb_ntt_input_loader;

  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_ready, wr_en, busy, load_done;
  logic [4:0]  a0, a1, a2, a3;
  logic [11:0] d0, d1, d2, d3;

  ntt_input_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // ------------------------------------------------------------ stimulus / model
  int stim [128];
  int ref_mem [4][32];

  function automatic void build_ref();
    for (int x = 0; x < 128; x++) begin
      int r, b;
      r = (stim[x] >= QM) ? stim[x] - QM : stim[x];
      b = ((x % 4) + ((x / 4) % 4) + ((x / 16) % 4) + (x / 64)) % 4;
      ref_mem[b][x / 4] = r;
    end
  endfunction

  // ------------------------------------------------------------ monitor
  int cyc = 0;
  int nacc, nwr, ndone, done_cyc, done_busy;
  int wa [32][4];
  int wd [32][4];
  int wcyc [32];

  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) nacc++;
    if (wr_en) begin
      if (nwr < 32) begin
        wa[nwr][0] = a0; wa[nwr][1] = a1; wa[nwr][2] = a2; wa[nwr][3] = a3;
        wd[nwr][0] = d0; wd[nwr][1] = d1; wd[nwr][2] = d2; wd[nwr][3] = d3;
        wcyc[nwr]  = cyc;
      end
      nwr++;
    end
    if (load_done) begin
      ndone++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  // ------------------------------------------------------------ driver
  task automatic do_load(input int bub, input bit spur, input int stop);
    int  idx;
    int  guard;
    bit  acc;
    bit  got;
    idx = 0; guard = 0; got = 0;
    nacc = 0; nwr = 0; ndone = 0; done_cyc = -1; done_busy = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_to_ready", in_ready, 1);
    while (idx < stop && guard < 5000) begin
      in_valid = ($urandom_range(0, 99) >= bub);
      in_data  = 12'(stim[idx]);
      start    = spur && (idx == 40);
      acc      = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) idx++;
    end
    start = 1'b0;
    if (idx < stop) chk("load_timeout", idx, stop);
    if (stop < 128) return;
    // keep offering data after the last accept; it must not be taken
    in_valid = 1'b1;
    in_data  = 12'hfff;
    guard = 0;
    while (!got && guard < 20) begin
      @(negedge clk);
      guard++;
      if (load_done) got = 1;
    end
    chk("done_seen", got, 1);
    if (spur) start = 1'b1;      // lands on the DONE cycle
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_ready_after_done", in_ready, 0);
    chk("idle_busy_after_done", busy, 0);
  endtask

  task automatic verify_load(input bit b2b);
    build_ref();
    chk("accepts", nacc, 128);
    chk("writes", nwr, 32);
    chk("done_pulses", ndone, 1);
    chk("done_after_last_write", done_cyc, wcyc[31] + 1);
    chk("busy_in_done", done_busy, 0);
    for (int w = 0; w < 32; w++) begin
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("addr w%0d b%0d", w, b), wa[w][b], w);
        chk($sformatf("data w%0d b%0d", w, b), wd[w][b], ref_mem[b][w]);
      end
      if (b2b && w > 0) chk($sformatf("spacing w%0d", w), wcyc[w] - wcyc[w-1], 4);
    end
  endtask

  // ------------------------------------------------------------ directed table
  typedef struct packed {
    logic [4:0]       g;
    logic [3:0][11:0] v;
    logic [3:0][11:0] e;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input int g, input int v0, input int v1, input int v2,
                              input int v3, input int e0, input int e1, input int e2,
                              input int e3);
    vec_t t;
    t.g = 5'(g);
    t.v[0] = 12'(v0); t.v[1] = 12'(v1); t.v[2] = 12'(v2); t.v[3] = 12'(v3);
    t.e[0] = 12'(e0); t.e[1] = 12'(e1); t.e[2] = 12'(e2); t.e[3] = 12'(e3);
    return t;
  endfunction

  initial begin
    // inputs v[k] for members x=4g+k; expected d0..d3 worked out from the bank map
    tbl[0] = mk(0,  0, 1, 2, 3,              0, 1, 2, 3);
    tbl[1] = mk(1,  4, 5, 6, 7,              7, 4, 5, 6);
    tbl[2] = mk(0,  3328, 3329, 4095, 0,     3328, 0, 766, 0);
    tbl[3] = mk(5,  100, 3330, 200, 4000,    200, 671, 100, 1);
    tbl[4] = mk(31, 3329, 3328, 1, 2,        3328, 1, 2, 0);

    // reset with in_valid high
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_a0", a0, 0);
    chk("rst_d3", d3, 0);
    #1 rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_accept_ready", in_ready, 0);
    chk("idle_no_write", wr_en, 0);
    in_valid = 1'b0;

    // table-driven back-to-back loads
    for (int t = 0; t < 5; t++) begin
      for (int x = 0; x < 128; x++) stim[x] = x;
      for (int k = 0; k < 4; k++) stim[tbl[t].g * 4 + k] = tbl[t].v[k];
      do_load(0, 1'b0, 128);
      verify_load(1'b1);
      for (int b = 0; b < 4; b++) begin
        chk($sformatf("tbl%0d addr b%0d", t, b), wa[tbl[t].g][b], int'(tbl[t].g));
        chk($sformatf("tbl%0d data b%0d", t, b), wd[tbl[t].g][b], int'(tbl[t].e[b]));
      end
    end

    // randomized bubbled loads, one with spurious starts in LOAD and DONE
    for (int r = 0; r < 3; r++) begin
      for (int x = 0; x < 128; x++) stim[x] = $urandom_range(0, 4095);
      do_load(35, r == 1, 128);
      verify_load(1'b0);
    end

    // reset in the middle of a load
    for (int x = 0; x < 128; x++) stim[x] = $urandom_range(0, 4095);
    do_load(20, 1'b0, 70);
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_load_done", load_done, 0);
    in_valid = 1'b0;
    for (int x = 0; x < 128; x++) stim[x] = $urandom_range(0, 4095);
    do_load(25, 1'b0, 128);
    verify_load(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
